// File: rtl/cluster_collector_pkg.sv
// Shared cluster-packer definitions: slot width, empty-slot code, {cnt,adr} packing
// and the frame-control state encoding used by the collector.
package cluster_collector_pkg;

  localparam int unsigned SLOT_ADR_W = 11;
  localparam int unsigned SLOT_CNT_W = 3;
  localparam int unsigned SLOT_W     = SLOT_CNT_W + SLOT_ADR_W;

  localparam logic [SLOT_ADR_W-1:0] EMPTY_ADR = 11'h7FF;

  typedef struct packed {
    logic [SLOT_CNT_W-1:0] cnt;
    logic [SLOT_ADR_W-1:0] adr;
  } slot_t;

  localparam slot_t EMPTY_SLOT = {3'd0, EMPTY_ADR};

  // Frame control: waiting for the first frame_start, inside the first frame
  // (no length reference yet), or running with a reference length.
  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_FIRST = 2'd1,
    ST_RUN   = 2'd2
  } frame_state_e;

  function automatic slot_t pack_slot(input logic [SLOT_CNT_W-1:0] cnt,
                                      input logic [SLOT_ADR_W-1:0] adr);
    slot_t s;
    s.cnt = cnt;
    s.adr = adr;
    return s;
  endfunction

endpackage

// File: rtl/cluster_collector_if.sv
// Encoder-to-collector bus plus the collector's frame report.
//   master : drives encoder signals (frame_start, cluster_found, adr, cnt), reads the report
//   slave  : the collector; reads encoder signals, drives clusters_out, out_valid,
//            cluster_count, overflow, bad_adr, frame_err
interface cluster_collector_if #(
  parameter int unsigned MXCLUSTERS = 8,
  parameter int unsigned MXADRBITS  = 11
);
  localparam int unsigned OUT_W = MXCLUSTERS * cluster_collector_pkg::SLOT_W;

  logic                 frame_start;
  logic                 cluster_found;
  logic [MXADRBITS-1:0] adr;
  logic [2:0]           cnt;
  logic [OUT_W-1:0]     clusters_out;
  logic                 out_valid;
  logic [3:0]           cluster_count;
  logic                 overflow;
  logic                 bad_adr;
  logic                 frame_err;

  modport master (
    output frame_start, cluster_found, adr, cnt,
    input  clusters_out, out_valid, cluster_count, overflow, bad_adr, frame_err
  );

  modport slave (
    input  frame_start, cluster_found, adr, cnt,
    output clusters_out, out_valid, cluster_count, overflow, bad_adr, frame_err
  );

endinterface

// File: rtl/cluster_slot_fifo.sv
// Slot store for one frame: slots fill in arrival order; writes past the last slot are dropped.
//   clk, rst_n : clock, async active-low reset
//   clear      : empty all slots; a simultaneous write lands in slot 0
//   write/data : append one slot
//   full       : all DEPTH slots used
//   count      : number of used slots
//   slots      : flattened slot contents, slot 0 in the low bits
module cluster_slot_fifo
  import cluster_collector_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    write,
  input  slot_t                   data,
  output logic                    full,
  output logic [CNT_W-1:0]        count,
  output logic [DEPTH*SLOT_W-1:0] slots
);

  slot_t            slot_q [DEPTH];
  logic [CNT_W-1:0] wptr_q;

  assign full  = (wptr_q == CNT_W'(DEPTH));
  assign count = wptr_q;

  // Slot storage and write pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) slot_q[i] <= EMPTY_SLOT;
      wptr_q <= '0;
    end else if (clear) begin
      for (int i = 0; i < int'(DEPTH); i++) slot_q[i] <= EMPTY_SLOT;
      if (write) slot_q[0] <= data;
      wptr_q <= write ? CNT_W'(1) : '0;
    end else if (write && !full) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (wptr_q == CNT_W'(i)) slot_q[i] <= data;
      end
      wptr_q <= wptr_q + CNT_W'(1);
    end
  end

  // Flatten for the frame report
  always_comb begin
    slots = '0;
    for (int i = 0; i < int'(DEPTH); i++) slots[i*SLOT_W +: SLOT_W] = slot_q[i];
  end

endmodule

// File: rtl/cluster_collector.sv
// Collects priority-encoder clusters into per-frame slots and reports the previous
// frame one cycle after each frame_start.
//   clock, reset_n : clock, async active-low reset
//   bus (slave)    : encoder inputs frame_start/cluster_found/adr/cnt;
//                    report clusters_out/out_valid/cluster_count/overflow/bad_adr/frame_err
module cluster_collector
  import cluster_collector_pkg::*;
#(
  parameter int unsigned MXCLUSTERS = 8,
  parameter int unsigned MXADRBITS  = 11,
  parameter int unsigned MXPADS     = 768
) (
  input logic                clock,
  input logic                reset_n,
  cluster_collector_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MXCLUSTERS + 1);
  localparam int unsigned LEN_W = 16;
  localparam int unsigned OUT_W = MXCLUSTERS * SLOT_W;

  logic                 in_range_c;
  logic                 dup_c;
  logic                 accept_c;
  logic                 fifo_write_c;
  slot_t                slot_c;
  logic                 fifo_full;
  logic [CNT_W-1:0]     fifo_count;
  logic [OUT_W-1:0]     fifo_slots;

  logic                 ovf_q;
  logic                 bad_q;
  logic                 last_valid_q;
  logic [MXADRBITS-1:0] last_adr_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     prev_len_q;

  frame_state_e         state_q;
  frame_state_e         state_d;
  logic                 publish_c;
  logic                 len_err_c;

  // Cluster qualification; the frame_start cycle never matches the old frame's last address
  assign in_range_c   = (32'(bus.adr) < MXPADS);
  assign dup_c        = last_valid_q && !bus.frame_start && (bus.adr == last_adr_q);
  assign accept_c     = bus.cluster_found && in_range_c && !dup_c;
  assign fifo_write_c = accept_c && (bus.frame_start || !fifo_full);
  assign slot_c       = pack_slot(bus.cnt, SLOT_ADR_W'(bus.adr));

  cluster_slot_fifo #(
    .DEPTH (MXCLUSTERS)
  ) u_slots (
    .clk   (clock),
    .rst_n (reset_n),
    .clear (bus.frame_start),
    .write (fifo_write_c),
    .data  (slot_c),
    .full  (fifo_full),
    .count (fifo_count),
    .slots (fifo_slots)
  );

  // Frame control state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_WAIT;
    else          state_q <= state_d;
  end

  // Frame control next state: publish from the second frame_start, check length from the third
  always_comb begin
    state_d   = state_q;
    publish_c = 1'b0;
    len_err_c = 1'b0;
    if (bus.frame_start) begin
      case (state_q)
        ST_WAIT:  state_d = ST_FIRST;
        ST_FIRST: begin
          state_d   = ST_RUN;
          publish_c = 1'b1;
        end
        ST_RUN: begin
          publish_c = 1'b1;
          len_err_c = (len_q != prev_len_q);
        end
        default:  state_d = ST_WAIT;
      endcase
    end
  end

  // Per-frame flags, duplicate tracking and frame length
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q        <= 1'b0;
      bad_q        <= 1'b0;
      last_valid_q <= 1'b0;
      last_adr_q   <= '0;
      len_q        <= '0;
      prev_len_q   <= '0;
    end else if (bus.frame_start) begin
      ovf_q        <= 1'b0;
      bad_q        <= bus.cluster_found && !in_range_c;
      last_valid_q <= accept_c;
      if (accept_c) last_adr_q <= bus.adr;
      len_q        <= LEN_W'(1);
      if (state_q != ST_WAIT) prev_len_q <= len_q;
    end else begin
      if (accept_c && fifo_full)             ovf_q <= 1'b1;
      if (bus.cluster_found && !in_range_c) bad_q <= 1'b1;
      if (accept_c) begin
        last_valid_q <= 1'b1;
        last_adr_q   <= bus.adr;
      end
      if (len_q != '1) len_q <= len_q + LEN_W'(1);
    end
  end

  // Report registers, held until the next publish
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.clusters_out  <= {MXCLUSTERS{EMPTY_SLOT}};
      bus.cluster_count <= 4'd0;
      bus.out_valid     <= 1'b0;
      bus.overflow      <= 1'b0;
      bus.bad_adr       <= 1'b0;
      bus.frame_err     <= 1'b0;
    end else begin
      bus.out_valid <= publish_c;
      if (publish_c) begin
        bus.clusters_out  <= fifo_slots;
        bus.cluster_count <= 4'(fifo_count);
        bus.overflow      <= ovf_q;
        bus.bad_adr       <= bad_q;
        bus.frame_err     <= len_err_c;
      end
    end
  end

endmodule

// File: tb/tb_cluster_collector.sv
// Directed bench for cluster_collector with hand-computed frame reports.
module tb_cluster_collector;

  localparam int unsigned NCL   = 8;
  localparam int unsigned OUT_W = NCL * 14;

  logic clock;
  logic reset_n;
  int   n_vec;
  int   n_err;
  int   n_strobe;

  logic [OUT_W-1:0] empty_all;
  logic [OUT_W-1:0] exp_slots;

  cluster_collector_if #(.MXCLUSTERS(NCL), .MXADRBITS(11)) bus ();

  cluster_collector #(
    .MXCLUSTERS (NCL),
    .MXADRBITS  (11),
    .MXPADS     (768)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] slot(input int c, input int a);
    return {3'(c), 11'(a)};
  endfunction

  // Present one cycle of encoder data, then sample 1 time unit after the edge
  task automatic drive(input logic fs, input logic found, input int a, input int c);
    bus.frame_start   = fs;
    bus.cluster_found = found;
    bus.adr           = 11'(a);
    bus.cnt           = 3'(c);
    @(posedge clock);
    #1;
    if (bus.out_valid) n_strobe++;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_slots"}, 128'(bus.clusters_out), 128'(empty_all));
    check({tag, "_count"}, 128'(bus.cluster_count), 128'(0));
    check({tag, "_valid"}, 128'(bus.out_valid), 128'(0));
    check({tag, "_ovf"},   128'(bus.overflow), 128'(0));
    check({tag, "_bad"},   128'(bus.bad_adr), 128'(0));
    check({tag, "_ferr"},  128'(bus.frame_err), 128'(0));
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    n_strobe = 0;
    for (int i = 0; i < int'(NCL); i++) empty_all[i*14 +: 14] = 14'h07FF;

    reset_n           = 1'b0;
    bus.frame_start   = 1'b0;
    bus.cluster_found = 1'b0;
    bus.adr           = '0;
    bus.cnt           = '0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_state("rst");
    reset_n = 1'b1;

    // Frame A (4 cycles): (5,1), (300,3); first frame_start must not strobe
    drive(1'b1, 1'b0, 0, 0);
    check("first_fs_no_valid", 128'(bus.out_valid), 128'(0));
    drive(1'b0, 1'b1, 5, 1);
    drive(1'b0, 1'b1, 300, 3);
    drive(1'b0, 1'b0, 0, 0);

    // Frame B starts with adr=42 in its frame_start cycle
    drive(1'b1, 1'b1, 42, 2);
    exp_slots          = empty_all;
    exp_slots[13:0]    = slot(1, 5);
    exp_slots[27:14]   = slot(3, 300);
    check("a_valid", 128'(bus.out_valid), 128'(1));
    check("a_count", 128'(bus.cluster_count), 128'(2));
    check("a_slots", 128'(bus.clusters_out), 128'(exp_slots));
    check("a_ovf",   128'(bus.overflow), 128'(0));
    check("a_bad",   128'(bus.bad_adr), 128'(0));
    check("a_ferr",  128'(bus.frame_err), 128'(0));
    drive(1'b0, 1'b0, 0, 0);
    check("a_strobe_one_cycle", 128'(bus.out_valid), 128'(0));
    drive(1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 0, 0);
    check("a_hold_slots", 128'(bus.clusters_out), 128'(exp_slots));
    check("a_strobes", 128'(n_strobe), 128'(1));

    // Frame C (5 cycles): bad adr 800, then 42 twice back to back
    drive(1'b1, 1'b0, 0, 0);
    exp_slots        = empty_all;
    exp_slots[13:0]  = slot(2, 42);
    check("b_valid", 128'(bus.out_valid), 128'(1));
    check("b_count", 128'(bus.cluster_count), 128'(1));
    check("b_slots", 128'(bus.clusters_out), 128'(exp_slots));
    check("b_ferr",  128'(bus.frame_err), 128'(0));
    check("b_strobes", 128'(n_strobe), 128'(2));
    drive(1'b0, 1'b1, 800, 1);
    drive(1'b0, 1'b1, 42, 4);
    drive(1'b0, 1'b1, 42, 4);
    drive(1'b0, 1'b0, 0, 0);

    // Frame D (10 cycles): ten distinct clusters, first one in the frame_start cycle
    drive(1'b1, 1'b1, 100, 0);
    exp_slots        = empty_all;
    exp_slots[13:0]  = slot(4, 42);
    check("c_count", 128'(bus.cluster_count), 128'(1));
    check("c_slots", 128'(bus.clusters_out), 128'(exp_slots));
    check("c_bad",   128'(bus.bad_adr), 128'(1));
    check("c_ovf",   128'(bus.overflow), 128'(0));
    check("c_ferr",  128'(bus.frame_err), 128'(1));
    for (int i = 1; i < 10; i++) drive(1'b0, 1'b1, 100 + i, i % 8);

    // Frame E: two clusters, then reset mid-frame
    drive(1'b1, 1'b0, 0, 0);
    for (int i = 0; i < int'(NCL); i++) exp_slots[i*14 +: 14] = slot(i % 8, 100 + i);
    check("d_count", 128'(bus.cluster_count), 128'(8));
    check("d_slots", 128'(bus.clusters_out), 128'(exp_slots));
    check("d_ovf",   128'(bus.overflow), 128'(1));
    check("d_bad",   128'(bus.bad_adr), 128'(0));
    check("d_ferr",  128'(bus.frame_err), 128'(1));
    drive(1'b0, 1'b1, 7, 1);
    drive(1'b0, 1'b1, 8, 2);
    #2 reset_n = 1'b0;
    #1;
    check_reset_state("midrst");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    n_strobe = 0;

    // After reset: first frame_start silent, next one reports an empty unchecked frame
    drive(1'b1, 1'b0, 0, 0);
    check("post_rst_first_fs", 128'(bus.out_valid), 128'(0));
    drive(1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 0, 0);
    check("post_rst_valid", 128'(bus.out_valid), 128'(1));
    check("post_rst_count", 128'(bus.cluster_count), 128'(0));
    check("post_rst_slots", 128'(bus.clusters_out), 128'(empty_all));
    check("post_rst_ferr",  128'(bus.frame_err), 128'(0));
    check("post_rst_strobes", 128'(n_strobe), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
